// File: rtl/req_encoder_pkg.sv
// Shared types and helpers for the 8-to-3 request encoder.
package req_encoder_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Expand an index into a one-hot line mask (used to clear the granted bit).
  function automatic logic [N-1:0] onehot_from_idx(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/req_encoder_8_3_prio_enc8.sv
// Combinational descending priority search over 8 lines, starting at start_i
// and wrapping from 0 back to 7.
module prio_enc8
  import req_encoder_pkg::*;
(
  input  logic [N-1:0]     vec_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  // First set bit at start_i, start_i-1, ... modulo 8 wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'(start_i - IDX_W'(i));
      if (!found_o && vec_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/req_encoder_8_3.sv
// Sequential 8-to-3 request encoder: sticky pending capture, priority grant
// on a valid/ready output, pending bit cleared on handshake.
// Optional build macro REQ_ENCODER_ROUND_ROBIN_EN switches selection from
// fixed highest-index priority to a rotating round-robin pointer.
module req_encoder_8_3 #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             any_pending,
  output logic             coalesced
);

  import req_encoder_pkg::*;

  // Only the 8-line configuration is supported in this revision.
  if (N != req_encoder_pkg::N || IDX_W != $clog2(N)) begin : g_bad_param
    $error("req_encoder_8_3 supports only N=8, IDX_W=3");
  end

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_valid_q, out_valid_d;
  logic             coalesced_q, coalesced_d;
  logic             any_pending_q, any_pending_d;

  logic             hs_c;
  logic [N-1:0]     clr_c;
  logic [N-1:0]     cap_c;
  logic [IDX_W-1:0] start_c;
  logic             sel_found_c;
  logic [IDX_W-1:0] sel_idx_c;

  assign hs_c  = out_valid_q & out_ready;
  assign clr_c = hs_c ? onehot_from_idx(out_idx_q) : '0;
  assign cap_c = req & {N{en}};

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer moves just below the line granted on each handshake.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs_c) begin
      rr_ptr_d = IDX_W'(out_idx_q - IDX_W'(1));
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= IDX_W'(N - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign start_c = rr_ptr_q;
`else
  assign start_c = IDX_W'(N - 1);
`endif

  prio_enc8 u_prio (
    .vec_i   (pending_q),
    .start_i (start_c),
    .found_o (sel_found_c),
    .idx_o   (sel_idx_c)
  );

  // Sticky capture: new requests win over the handshake clear.
  always_comb begin
    pending_d     = (pending_q & ~clr_c) | cap_c;
    any_pending_d = |pending_d;
    coalesced_d   = coalesced_q | (|(cap_c & pending_q & ~clr_c));
  end

  // Grant FSM: pick from registered pending in IDLE, hold until accepted.
  always_comb begin
    state_d     = state_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (sel_found_c) begin
          out_idx_d   = sel_idx_c;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        out_valid_d = 1'b1;
        if (hs_c) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      out_idx_q     <= '0;
      out_valid_q   <= 1'b0;
      coalesced_q   <= 1'b0;
      any_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      out_idx_q     <= out_idx_d;
      out_valid_q   <= out_valid_d;
      coalesced_q   <= coalesced_d;
      any_pending_q <= any_pending_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign pending     = pending_q;
  assign any_pending = any_pending_q;
  assign coalesced   = coalesced_q;

endmodule

// File: tb/tb_req_encoder_8_3.sv
// Self-checking bench for req_encoder_8_3 with a cycle-level reference model.
module tb_req_encoder_8_3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       any_pending;
  logic       coalesced;

  int checks;
  int errors;

  // Reference model state
  logic [7:0] m_pend;
  logic       m_valid;
  int         m_idx;
  logic       m_coal;
  int         m_ptr;

  req_encoder_8_3 dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .pending     (pending),
    .any_pending (any_pending),
    .coalesced   (coalesced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by the spec rules using current inputs, then clock the DUT.
  task automatic tick();
    logic [7:0] old_pend;
    logic       hs;
    int         start;
    int         k;
    bit         got;
    if (rst) begin
      m_pend  = 8'h00;
      m_valid = 1'b0;
      m_idx   = 0;
      m_coal  = 1'b0;
      m_ptr   = 7;
    end else begin
      old_pend = m_pend;
      hs = m_valid && out_ready;
      for (int b = 0; b < 8; b++) begin
        bit cleared;
        cleared = hs && (b == m_idx);
        if (en && req[b] && old_pend[b] && !cleared) m_coal = 1'b1;
        m_pend[b] = (old_pend[b] && !cleared) || (en && req[b]);
      end
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0;
          m_ptr   = (m_idx + 7) % 8;
        end
      end else if (old_pend != 8'h00) begin
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 7;
`endif
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
          k = (start - i + 8) % 8;
          if (!got && old_pend[k]) begin
            got   = 1'b1;
            m_idx = k;
          end
        end
        m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 8'hFF; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0; en = 1'b0; req = 8'h00; out_ready = 1'b0;
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h expected 00", pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", out_idx); end
    checks++; if (coalesced !== 1'b0) begin errors++; $display("FAIL reset_coalesced: got %b expected 0", coalesced); end
    checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL reset_any: got %b expected 0", any_pending); end
    en = 1'b0; req = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (pending !== 8'h00) begin errors++; $display("FAIL en_low_pending cyc%0d: got %h expected 00", c, pending); end
    end
    req = 8'h00;
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; out_ready = 1'b1; req = 8'h10;
    tick();
    req = 8'h00;
    checks++; if (pending !== 8'h10 || out_valid !== 1'b0) begin errors++; $display("FAIL single_capture: got pend=%h valid=%b expected pend=10 valid=0", pending, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd4) begin errors++; $display("FAIL single_grant: got valid=%b idx=%0d expected valid=1 idx=4", out_valid, out_idx); end
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 8'h00 || any_pending !== 1'b0) begin errors++; $display("FAIL single_clear: got valid=%b pend=%h any=%b expected 0/00/0", out_valid, pending, any_pending); end
  endtask

  task automatic test_fixed_drain();
    int grants[$];
    int times[$];
    int exp_g[3];
    exp_g[0] = 5; exp_g[1] = 2; exp_g[2] = 0;
    do_reset();
    en = 1'b1; out_ready = 1'b1; req = 8'h25;
    tick();
    req = 8'h00;
    for (int c = 0; c < 20 && grants.size() < 3; c++) begin
      tick();
      if (out_valid === 1'b1) begin grants.push_back(int'(out_idx)); times.push_back(c); end
    end
    checks++;
    if (grants.size() != 3) begin
      errors++; $display("FAIL drain_count: got %0d grants expected 3", grants.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (grants[i] != exp_g[i]) begin errors++; $display("FAIL drain_grant%0d: got %0d expected %0d", i, grants[i], exp_g[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++; if (times[i] - times[i-1] != 2) begin errors++; $display("FAIL drain_spacing%0d: got %0d expected 2", i, times[i] - times[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_next;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    exp_next = 0;
`else
    exp_next = 7;
`endif
    do_reset();
    en = 1'b1; out_ready = 1'b0; req = 8'h03;
    tick();
    req = 8'h00;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd1) begin errors++; $display("FAIL bp_first: got valid=%b idx=%0d expected 1/1", out_valid, out_idx); end
    req = 8'h80;
    for (int c = 0; c < 6; c++) begin
      tick();
      req = 8'h00;
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'd1) begin errors++; $display("FAIL bp_hold cyc%0d: got valid=%b idx=%0d expected 1/1", c, out_valid, out_idx); end
    end
    checks++; if (pending !== 8'h83) begin errors++; $display("FAIL bp_pending: got %h expected 83", pending); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || int'(out_idx) != exp_next) begin errors++; $display("FAIL bp_next: got valid=%b idx=%0d expected 1/%0d", out_valid, out_idx, exp_next); end
    out_ready = 1'b0;
  endtask

  task automatic test_set_beats_clear();
    do_reset();
    en = 1'b1; out_ready = 1'b0; req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || coalesced !== 1'b0) begin errors++; $display("FAIL sbc_grant: got valid=%b idx=%0d coal=%b expected 1/3/0", out_valid, out_idx, coalesced); end
    req = 8'h08;
    tick();
    checks++; if (coalesced !== 1'b1) begin errors++; $display("FAIL sbc_coalesced: got %b expected 1", coalesced); end
    out_ready = 1'b1;
    tick();
    req = 8'h00;
    checks++; if (pending !== 8'h08 || out_valid !== 1'b0) begin errors++; $display("FAIL sbc_keep: got pend=%h valid=%b expected 08/0", pending, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin errors++; $display("FAIL sbc_regrant: got valid=%b idx=%0d expected 1/3", out_valid, out_idx); end
    tick();
    checks++; if (pending !== 8'h00 || coalesced !== 1'b1) begin errors++; $display("FAIL sbc_drain: got pend=%h coal=%b expected 00/1", pending, coalesced); end
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int grants[$];
    int exp_g[4];
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    exp_g[0] = 7; exp_g[1] = 0; exp_g[2] = 7; exp_g[3] = 0;
`else
    exp_g[0] = 7; exp_g[1] = 7; exp_g[2] = 7; exp_g[3] = 7;
`endif
    do_reset();
    en = 1'b1; out_ready = 1'b1; req = 8'h81;
    for (int c = 0; c < 30 && grants.size() < 4; c++) begin
      tick();
      if (out_valid === 1'b1) grants.push_back(int'(out_idx));
    end
    req = 8'h00;
    checks++;
    if (grants.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d grants expected 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (grants[i] != exp_g[i]) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", i, grants[i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 3) != 0);
      req       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (pending !== m_pend || out_valid !== m_valid || any_pending !== (m_pend != 8'h00) ||
          coalesced !== m_coal || (m_valid && int'(out_idx) != m_idx)) begin
        errors++;
        $display("FAIL random cyc%0d: got pend=%h valid=%b idx=%0d any=%b coal=%b expected pend=%h valid=%b idx=%0d any=%b coal=%b",
                 c, pending, out_valid, out_idx, any_pending, coalesced,
                 m_pend, m_valid, m_idx, (m_pend != 8'h00), m_coal);
      end
    end
    rst = 1'b0; en = 1'b0; req = 8'h00; out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; en = 1'b0; req = 8'h00; out_ready = 1'b0;
    m_pend = 8'h00; m_valid = 1'b0; m_idx = 0; m_coal = 1'b0; m_ptr = 7;
    test_reset();
    test_single();
    test_fixed_drain();
    test_backpressure();
    test_set_beats_clear();
    test_round_robin();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
